// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding datapath: source indices,
// default sizes and the select-width helper.
package fwd_pkg;

  localparam int FWD_RF     = 0;
  localparam int FWD_EX_MEM = 1;
  localparam int FWD_MEM_WB = 2;
  localparam int FWD_WB     = 3;
  localparam int FWD_IMM    = 4;

  localparam int FWD_WIDTH  = 32;
  localparam int FWD_NUM_IN = 5;

  // A single input still needs a 1-bit select so the port never collapses to zero width.
  function automatic int fwd_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_sel_mux.sv
// Combinational N-way selector with explicit illegal-index detection;
// out-of-range selects yield zero data rather than X.
module param_sel_mux
  import fwd_pkg::*;
#(
  parameter int WIDTH  = FWD_WIDTH,
  parameter int NUM_IN = FWD_NUM_IN,
  localparam int SEL_W = fwd_sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic                    illegal
);

  logic [WIDTH-1:0] masked [NUM_IN];

  // One-hot AND-OR structure: each lane contributes only when its index matches.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_mask
      assign masked[gi] = (sel == SEL_W'(gi)) ? in_data[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data = sel_data | masked[i];
    end
  end

  // Extra MSB keeps the compare meaningful when NUM_IN fills the select range.
  assign illegal = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

endmodule

// File: rtl/fwd_select_stage.sv
// Registered forwarding selector with valid/ready handshake, 2-entry skid
// buffer, flush, and sticky/saturating illegal-select tracking.
module fwd_select_stage
  import fwd_pkg::*;
#(
  parameter int WIDTH  = FWD_WIDTH,
  parameter int NUM_IN = FWD_NUM_IN,
  parameter int CNT_W  = 8,
  localparam int SEL_W = fwd_sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    err_clear
);

  logic [WIDTH-1:0] sel_data;
  logic             illegal;

  logic             main_valid_reg, main_valid_next;
  logic [WIDTH-1:0] main_data_reg,  main_data_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
  logic             sel_err_reg,    sel_err_next;
  logic [CNT_W-1:0] err_count_reg,  err_count_next;

  logic accept;
  logic main_free;
  logic err_event;

  param_sel_mux #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .sel_data (sel_data),
    .illegal  (illegal)
  );

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
  assign in_ready  = ~skid_valid_reg;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid_reg | out_ready;
  assign err_event = accept & illegal & ~flush;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = accept;
        if (accept) skid_data_next = sel_data;
      end else begin
        main_valid_next = accept;
        if (accept) main_data_next = sel_data;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = sel_data;
    end
  end

  // A new illegal event overrides a simultaneous clear and restarts the count at one.
  always_comb begin
    sel_err_next   = sel_err_reg;
    err_count_next = err_count_reg;
    if (err_event) begin
      sel_err_next = 1'b1;
      if (err_clear)
        err_count_next = CNT_W'(1);
      else if (err_count_reg != {CNT_W{1'b1}})
        err_count_next = err_count_reg + CNT_W'(1);
    end else if (err_clear) begin
      sel_err_next   = 1'b0;
      err_count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      sel_err_reg    <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      sel_err_reg    <= sel_err_next;
      err_count_reg  <= err_count_next;
    end
  end

  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign sel_err   = sel_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: doc/fwd_select_stage.md
Name: fwd_select_stage

Overview:
Parametrised, registered N-way operand-forwarding selector for the pipelined core. It replaces the fixed 5-way combinational forwarding mux used in front of the ALU and adds:
- a valid/ready handshake with a 2-entry skid buffer, so stalls do not create combinational ready paths;
- flush support for branch mispredicts and traps;
- illegal-select detection with zero output instead of high-Z;
- a sticky error flag and a saturating error counter.

Parameters:
WIDTH, 32, data width of each input and of the output.
NUM_IN, 5, number of selectable inputs; legal range 1..16.
CNT_W, 8, width of the saturating illegal-select counter.
SEL_W (localparam), max(1, clog2(NUM_IN)), select width; 3 for the defaults.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
in_sel  input  SEL_W  select index.
in_valid  input  1  upstream has a beat.
in_ready  output  1  stage can accept a beat.
out_data  output  WIDTH  selected, registered data.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts the beat.
flush  input  1  discard all held and incoming beats.
sel_err  output  1  sticky flag: at least one illegal select was accepted.
err_count  output  CNT_W  number of illegal selects accepted; saturating.
err_clear  input  1  clears sel_err and err_count.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid = 0, out_data = 0;
  - skid buffer empty;
  - in_ready = 1;
  - sel_err = 0, err_count = 0.
- Accept and release:
  - A beat is accepted on a rising edge when in_valid && in_ready.
  - A beat is released when out_valid && out_ready.
- Selection:
  - sel_data = input[in_sel] when in_sel < NUM_IN.
  - Otherwise sel_data = 0 and the beat is illegal. This is never X or Z.
- Storage: a main register (drives out_data/out_valid) and one skid register.
- in_ready is registered and equals !skid_valid. There is no combinational path from out_ready to in_ready.
- Latency and throughput:
  - An accepted beat appears on out_data the next cycle when main is empty or main releases in the same cycle.
  - Sustained throughput is 1 beat per cycle.
- Main register empty, or releasing this cycle:
  - A skid beat, if present, moves to main first.
  - Otherwise the incoming beat loads main directly.
  - If skid moves to main and a new beat is accepted in the same cycle, the new beat goes into skid.
- Main register full and not releasing:
  - An accepted beat goes to skid, and in_ready drops the next cycle.
- Ordering: strictly FIFO; beats are never reordered or duplicated.
- out_data holds its value while out_valid && !out_ready (stable under backpressure).
- Flush (priority over every transfer):
  - Next cycle: main and skid are empty, out_valid = 0, in_ready = 1.
  - A beat presented in the flush cycle is dropped, and its illegal select is not counted.
  - out_data keeps its last value (don't-care while out_valid = 0).
- Error tracking:
  - An accepted, non-flushed illegal beat sets sel_err and increments err_count.
  - err_count saturates at 2^CNT_W-1.
  - err_clear alone gives sel_err = 0 and err_count = 0 the next cycle.
  - err_clear together with an illegal accept gives sel_err = 1 and err_count = 1; the new event wins over the clear.
  - Errors are counted at accept time, not at release.
- NUM_IN = 2^SEL_W means no select is illegal; sel_err stays 0.
- Reset asserted mid-transfer immediately clears all state and outputs to the reset values. No beat survives reset.

Decomposition:
- Shared package fwd_pkg:
  - localparams for the forwarding source indices: FWD_RF = 0, FWD_EX_MEM = 1, FWD_MEM_WB = 2, FWD_WB = 3, FWD_IMM = 4;
  - default FWD_WIDTH = 32 and FWD_NUM_IN = 5;
  - a clog2-based select-width function.
- One natural sub-module, param_sel_mux: purely combinational, parameters WIDTH, NUM_IN; outputs sel_data and illegal. It is reused by other datapath selectors.

Test Plan:
- Reset then streaming: defaults; in_data inputs 0..4 = 0x11,0x22,0x33,0x44,0x55; sel 0,1,2,3,4 on back-to-back cycles with out_ready = 1 -> out_data sequence 0x11..0x55, each 1 cycle after accept; no gaps; in_ready stays 1.
- Backpressure: hold out_ready = 0 while sending sel = 2 then sel = 3 -> out_data = 0x33 held stable; skid holds 0x44; in_ready = 0 the next cycle. Release out_ready -> 0x33 then 0x44 in order, and in_ready returns to 1.
- Illegal select: sel = 5, 6, 7 accepted -> out_data = 0 for each beat; sel_err = 1; err_count = 3. err_clear pulsed together with another sel = 7 accept -> err_count = 1, sel_err = 1.
- Saturation: CNT_W = 2, five illegal accepts -> err_count stops at 3.
- Flush: main and skid both full, flush asserted with in_valid = 1 and sel = 6 -> next cycle out_valid = 0, in_ready = 1, err_count unchanged.
- Async reset mid-stream: drop rst_n between clock edges while out_valid = 1 -> out_valid, sel_err and err_count go to 0 immediately, without waiting for a clock edge.
